des_perm_pipe: RTL and testbench
================================

Name: des_perm_pipe

Overview:
- Pipelined, multi-lane DES bit-permutation engine with valid/ready flow control.
- Performs either the final permutation FP (IP^-1) or the initial permutation IP, selected per beat.
- Sits between the descrypt round pipeline and the result comparator/output FIFO.
- Carries an opaque tag (candidate/salt index) alongside the data so results stay associated with their candidates.

Parameters:
- LANES, 1: number of independent 64-bit blocks per beat; all lanes share one mode bit.
- STAGES, 2: register stages between input and output, legal range 1..4.
- TAG_WIDTH, 8: width of the pass-through tag; legal range 1..32.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  engine accepts a beat this cycle.
- in_mode  in  1  0 = FP, 1 = IP.
- in_tag  in  TAG_WIDTH  tag travelling with the beat.
- din  in  64*LANES  lane k occupies bits [64k+63:64k].
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output.
- out_tag  out  TAG_WIDTH  tag of the output beat.
- dout  out  64*LANES  permuted lanes, same lane layout as din.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- FP per lane: for output bit j (0..63), let r = (63-j) div 8 and c = (63-j) mod 8.
  - dout[j] = din[S[c] + r], where S = {24,56,16,48,8,40,0,32} for c = 0..7.
- IP per lane: exact inverse of FP, so IP(FP(x)) = x for every x.
- Permutation is applied combinationally at the input of stage 0. Later stages only register the result.
- Each stage holds {valid, mode, tag, data}.
  - Stage i advances when it is empty or stage i+1 advances.
  - The last stage advances when out_valid && out_ready, or when it is empty.
- in_ready = !valid[0] || advance[0].
  - Full throughput: 1 beat per cycle with out_ready held high.
- A transfer occurs on in_valid && in_ready. Data is captured into stage 0 on that edge.
- Latency from accepted input to out_valid = STAGES cycles with no back-pressure.
- out_valid, out_tag and dout come directly from the last stage register; no combinational path from din to dout.
- Back-pressure:
  - With out_ready = 0, the pipeline fills. After STAGES beats are held, in_ready = 0.
  - Held output data and tag are stable while out_valid = 1 && out_ready = 0.
- Simultaneous events: input accept and output drain in the same cycle on a full pipeline are legal; occupancy is unchanged and no beat is lost or duplicated.
- Per-beat mode: mixed FP/IP beats back-to-back are each permuted by their own mode bit.
- Beats emerge in input order; no reordering.
- Reset:
  - Clears all stage valid bits, and sets dout = 0, out_tag = 0, out_valid = 0, busy = 0.
  - in_ready = 1 on the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats.
  - A beat presented during reset is not accepted.
- in_ready must not depend on in_valid.
- Illegal STAGES or TAG_WIDTH values stop elaboration with an error.

Optional Feature:
- Macro DES_PERM_SWAP_EN.
- Defined:
  - Adds port in_swap (1 bit), carried with the beat.
  - When in_swap = 1, each lane's 32-bit halves are exchanged before the permutation: {din[31:0], din[63:32]}. This implements DES's final L/R swap inside the engine.
  - Latency and handshake are unchanged.
- Not defined: the port is absent and no swap logic exists; behaviour is identical to in_swap = 0.

Test Plan:
- Single lane, STAGES = 2, FP, din = 64'h0000000000000001, tag 8'h5A.
  - dout = 64'h0200000000000000 and out_tag = 8'h5A exactly 2 cycles after accept.
- Round trip: FP of 64'h0123456789ABCDEF, result fed back in IP mode.
  - Second output = 64'h0123456789ABCDEF.
  - Repeat with 1000 random values in all LANES = 4 lanes.
- Back-pressure, STAGES = 3: 5 beats (tags 1..5), out_ready = 0 for 6 cycles, then 1.
  - in_ready drops after 3 accepts.
  - Outputs emerge with tags 1,2,3,4,5 in order; held dout is stable while stalled.
- Full throughput with alternating mode bits and out_ready = 1.
  - One output per cycle; each output matches the reference model for its own mode.
- Reset asserted with 2 beats in flight.
  - out_valid = 0, busy = 0, dout = 0 the next cycle.
  - No stale beat appears after reset deasserts.
- With DES_PERM_SWAP_EN: in_swap = 1, FP, din = 64'h0000000100000000.
  - dout = 64'h0200000000000000.

Source files
------------

// File: rtl/des_perm_pipe_if.sv
// Bus bundle for des_perm_pipe: input beat handshake, output beat handshake, status.
// Latency: none. This file only groups wires.
// Backpressure: in_ready/out_ready follow valid-ready rules. A beat moves when valid && ready.
// Ports (slave = engine side):
//    in_valid/in_ready   input beat handshake
//    in_mode             0 = FP, 1 = IP
//    in_tag              opaque tag that travels with the beat
//    din                 lane k at bits [64k+63:64k]
//    in_swap             swap 32-bit halves before the permutation (DES_PERM_SWAP_EN builds only)
//    out_valid/out_ready output beat handshake
//    out_tag, dout       tag and permuted lanes of the output beat
//    busy                any stage occupied
interface des_perm_pipe_if #(
   parameter int LANES     = 1,
   parameter int TAG_WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic                   in_mode;
   logic [TAG_WIDTH-1:0]   in_tag;
   logic [64*LANES-1:0]    din;
`ifdef DES_PERM_SWAP_EN
   logic                   in_swap;
`endif
   logic                   out_valid;
   logic                   out_ready;
   logic [TAG_WIDTH-1:0]   out_tag;
   logic [64*LANES-1:0]    dout;
   logic                   busy;

   modport slave (
`ifdef DES_PERM_SWAP_EN
      input  in_swap,
`endif
      input  in_valid, in_mode, in_tag, din, out_ready,
      output in_ready, out_valid, out_tag, dout, busy
   );

   modport master (
`ifdef DES_PERM_SWAP_EN
      output in_swap,
`endif
      output in_valid, in_mode, in_tag, din, out_ready,
      input  in_ready, out_valid, out_tag, dout, busy
   );
endinterface

// File: rtl/des_perm_pipe.sv
// Multi-lane DES FP/IP bit-permutation pipeline. The tag travels with each beat.
// Latency: STAGES cycles from accept to out_valid. Throughput is 1 beat per cycle.
// Backpressure: a stage advances when it is empty or the stage after it advances.
//    in_ready is low only when every stage is full and the output is stalled.
// Ports: CLK and reset (synchronous, active-high) are plain ports.
//    All beat traffic uses the slave modport of des_perm_pipe_if.
// Optional macro DES_PERM_SWAP_EN adds bus.in_swap. It exchanges the 32-bit halves of
//    each lane before the permutation (the DES final L/R swap).
module des_perm_pipe #(
   parameter int LANES     = 1,
   parameter int STAGES    = 2,
   parameter int TAG_WIDTH = 8
) (
   input  logic             CLK,
   input  logic             reset,
   des_perm_pipe_if.slave   bus
);

   localparam int DW = 64 * LANES;

   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("des_perm_pipe: STAGES must be in 1..4");
   end
   if (TAG_WIDTH < 1 || TAG_WIDTH > 32) begin : g_bad_tag
      $error("des_perm_pipe: TAG_WIDTH must be in 1..32");
   end
   if (LANES < 1) begin : g_bad_lanes
      $error("des_perm_pipe: LANES must be at least 1");
   end

   // FP source column base. Output bit j reads input bit s_base(c) + r.
   //    r = (63-j) / 8 and c = (63-j) % 8.
   //    63-j is simply ~j on 6 bits.
   function automatic logic [5:0] s_base(input logic [2:0] c);
      case (c)
         3'd0: s_base = 6'd24;
         3'd1: s_base = 6'd56;
         3'd2: s_base = 6'd16;
         3'd3: s_base = 6'd48;
         3'd4: s_base = 6'd8;
         3'd5: s_base = 6'd40;
         3'd6: s_base = 6'd0;
         default: s_base = 6'd32;
      endcase
   endfunction

   function automatic logic [5:0] fp_src(input logic [5:0] j);
      logic [5:0] inv;
      inv    = ~j;
      fp_src = s_base(inv[2:0]) + {3'b000, inv[5:3]};
   endfunction

   function automatic logic [63:0] fp64(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(i)] = x[fp_src(6'(i))];
      return y;
   endfunction

   // IP scatters each bit back to where FP gathered it from, so IP(FP(x)) == x.
   function automatic logic [63:0] ip64(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[fp_src(6'(i))] = x[6'(i)];
      return y;
   endfunction

   // Mode is consumed at stage 0, so later stages hold only valid, tag and data.
   logic [STAGES-1:0]     sv;
   logic [DW-1:0]         sdat [STAGES];
   logic [TAG_WIDTH-1:0]  stag [STAGES];
   logic [STAGES-1:0]     adv;
   logic [DW-1:0]         perm_out;

   always_comb begin : p_perm
      logic [63:0] lane;
      lane     = '0;
      perm_out = '0;
      for (int k = 0; k < LANES; k++) begin
         lane = bus.din[64*k +: 64];
`ifdef DES_PERM_SWAP_EN
         if (bus.in_swap) lane = {lane[31:0], lane[63:32]};
`endif
         perm_out[64*k +: 64] = bus.in_mode ? ip64(lane) : fp64(lane);
      end
   end

   // Stage i can move if any stage from i to the end has a hole, or the output drains.
   //    This is the flattened form of "empty or next stage advances".
   //    It avoids a self-referencing vector.
   always_comb begin
      adv = '0;
      for (int i = 0; i < STAGES; i++) begin
         adv[i] = bus.out_ready;
         for (int k = i; k < STAGES; k++) begin
            if (!sv[k]) adv[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         sv <= '0;
         for (int i = 0; i < STAGES; i++) begin
            sdat[i] <= '0;
            stag[i] <= '0;
         end
      end else begin
         if (adv[0]) begin
            sv[0] <= bus.in_valid;
            if (bus.in_valid) begin
               sdat[0] <= perm_out;
               stag[0] <= bus.in_tag;
            end
         end
         // Payload moves only with a valid beat, so a stalled or drained output keeps its last data.
         for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
               sv[i] <= sv[i-1];
               if (sv[i-1]) begin
                  sdat[i] <= sdat[i-1];
                  stag[i] <= stag[i-1];
               end
            end
         end
      end
   end

   assign bus.in_ready  = !sv[0] || adv[0];
   assign bus.out_valid = sv[STAGES-1];
   assign bus.dout      = sdat[STAGES-1];
   assign bus.out_tag   = stag[STAGES-1];
   assign bus.busy      = |sv;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe.
// Two instances: 1 lane with 2 stages, and 4 lanes with 3 stages.
// Expected values are hand-computed, or built from the textbook DES IP/FP tables.
module tb_des_perm_pipe;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   des_perm_pipe_if #(.LANES(1), .TAG_WIDTH(8)) if1 ();
   des_perm_pipe_if #(.LANES(4), .TAG_WIDTH(8)) if4 ();

   des_perm_pipe #(.LANES(1), .STAGES(2), .TAG_WIDTH(8)) dut1 (
      .CLK(CLK), .reset(reset), .bus(if1.slave));
   des_perm_pipe #(.LANES(4), .STAGES(3), .TAG_WIDTH(8)) dut4 (
      .CLK(CLK), .reset(reset), .bus(if4.slave));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Textbook DES tables. DES bit n (1 = MSB) is vector bit 64-n.
   function automatic logic [63:0] m_fp(input logic [63:0] x);
      int tbl[8];
      logic [63:0] y;
      tbl = '{40, 8, 48, 16, 56, 24, 64, 32};
      y = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            y[64 - (8*r + c + 1)] = x[64 - (tbl[c] - r)];
      return y;
   endfunction

   function automatic logic [63:0] m_ip(input logic [63:0] x);
      logic [63:0] y;
      int first;
      y = '0;
      for (int r = 0; r < 8; r++) begin
         first = (r < 4) ? 58 + 2*r : 57 + 2*(r-4);
         for (int c = 0; c < 8; c++)
            y[64 - (8*r + c + 1)] = x[64 - (first - 8*c)];
      end
      return y;
   endfunction

   function automatic logic [255:0] m4(input logic mode, input logic [255:0] x);
      logic [255:0] y;
      for (int k = 0; k < 4; k++)
         y[64*k +: 64] = mode ? m_ip(x[64*k +: 64]) : m_fp(x[64*k +: 64]);
      return y;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic run1(input string tag, input logic mode, input logic [63:0] x,
                       input logic [7:0] t, input logic [63:0] exp);
      int lat;
      if1.in_valid = 1'b1; if1.in_mode = mode; if1.din = x; if1.in_tag = t;
      if1.out_ready = 1'b1;
      tick();
      if1.in_valid = 1'b0;
      lat = 1;
      while (!if1.out_valid && lat < 20) begin tick(); lat++; end
      chk({tag, "_lat"}, lat, 2);
      chk({tag, "_dat"}, if1.dout, exp);
      chk({tag, "_tag"}, if1.out_tag, t);
      tick();
   endtask

   task automatic run4(input string tag, input logic mode, input logic [255:0] x,
                       input logic [7:0] t, input logic [255:0] exp, output logic [255:0] got);
      int lat;
      if4.in_valid = 1'b1; if4.in_mode = mode; if4.din = x; if4.in_tag = t;
      if4.out_ready = 1'b1;
      tick();
      if4.in_valid = 1'b0;
      lat = 1;
      while (!if4.out_valid && lat < 20) begin tick(); lat++; end
      got = if4.dout;
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_dat"}, if4.dout, exp);
      chk({tag, "_tag"}, if4.out_tag, t);
      tick();
   endtask

   initial begin
      logic [63:0]  q1_dat[$];
      logic [7:0]   q1_tag[$];
      logic [255:0] q4_dat[$];
      logic [7:0]   q4_tag[$];
      logic [255:0] x4, r4, held, xb[5];
      logic [7:0]   held_tag;
      logic [63:0]  v;
      int got_n, first, last, stale, sent, recv, acc_stall, held_bad;
      logic held_ok;

      reset = 1'b1;
      if1.in_valid = 0; if1.in_mode = 0; if1.in_tag = 0; if1.din = 0; if1.out_ready = 1;
      if4.in_valid = 0; if4.in_mode = 0; if4.in_tag = 0; if4.din = 0; if4.out_ready = 1;
`ifdef DES_PERM_SWAP_EN
      if1.in_swap = 0; if4.in_swap = 0;
`endif
      repeat (3) tick();
      chk("rst_out_valid", if1.out_valid, 0);
      chk("rst_busy", if1.busy, 0);
      chk("rst_dout", if1.dout, 0);
      chk("rst_tag", if1.out_tag, 0);
      reset = 1'b0;
      #1;
      chk("rst_in_ready", if1.in_ready, 1);
      chk("rst_in_ready4", if4.in_ready, 1);

      // Directed single-lane vectors
      run1("fp_bit0", 1'b0, 64'h0000000000000001, 8'h5A, 64'h0200000000000000);
      run1("ip_bit57", 1'b1, 64'h0200000000000000, 8'hA5, 64'h0000000000000001);
      run1("fp_bit63", 1'b0, 64'h8000000000000000, 8'h01, 64'h0000000000000040);
      run1("ip_bit6", 1'b1, 64'h0000000000000040, 8'h02, 64'h8000000000000000);
      run1("ip_classic", 1'b1, 64'h0123456789ABCDEF, 8'h03, 64'hCC00CCFFF0AAF0AA);
      run1("fp_classic", 1'b0, 64'hCC00CCFFF0AAF0AA, 8'h04, 64'h0123456789ABCDEF);
`ifdef DES_PERM_SWAP_EN
      if1.in_swap = 1'b1;
      run1("fp_swap", 1'b0, 64'h0000000100000000, 8'h06, 64'h0200000000000000);
      if1.in_swap = 1'b0;
`endif

      // Full throughput, alternating mode
      got_n = 0; first = -1; last = -1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (if1.out_valid) begin
            if (q1_dat.size() == 0) chk("tput_extra", 1, 0);
            else begin
               chk("tput_dat", if1.dout, q1_dat.pop_front());
               chk("tput_tag", if1.out_tag, q1_tag.pop_front());
            end
            if (first < 0) first = cyc;
            last = cyc;
            got_n++;
         end
         if (cyc < 8) begin
            v = {$urandom, $urandom};
            if1.in_valid = 1'b1; if1.in_mode = cyc[0]; if1.din = v; if1.in_tag = 8'(cyc + 16);
            #1;
            if (if1.in_ready) begin
               q1_dat.push_back(cyc[0] ? m_ip(v) : m_fp(v));
               q1_tag.push_back(8'(cyc + 16));
            end
         end else if1.in_valid = 1'b0;
         tick();
      end
      chk("tput_count", got_n, 8);
      chk("tput_span", last - first, 7);

      // Reset with two beats in flight; a beat held during reset must be dropped
      if1.in_valid = 1; if1.in_mode = 0; if1.din = 64'h1111; if1.in_tag = 8'h21;
      tick();
      if1.din = 64'h2222; if1.in_tag = 8'h22;
      tick();
      if1.din = 64'h3333; if1.in_tag = 8'h23;
      reset = 1'b1;
      tick();
      chk("midrst_out_valid", if1.out_valid, 0);
      chk("midrst_busy", if1.busy, 0);
      chk("midrst_dout", if1.dout, 0);
      tick();
      reset = 1'b0; if1.in_valid = 1'b0;
      stale = 0;
      repeat (6) begin
         tick();
         if (if1.out_valid || if1.busy) stale++;
      end
      chk("midrst_stale", stale, 0);

      // Four lanes, lane-independent hand vector
      run4("lanes4", 1'b0,
           {64'h0, 64'h8000000000000000, 64'hCC00CCFFF0AAF0AA, 64'h0000000000000001}, 8'h77,
           {64'h0, 64'h0000000000000040, 64'h0123456789ABCDEF, 64'h0200000000000000}, r4);

      // Back-pressure on the 3-stage instance
      for (int i = 0; i < 5; i++)
         xb[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sent = 0; recv = 0; acc_stall = 0; held_bad = 0; held_ok = 1'b0;
      held = '0; held_tag = '0;
      for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
         if4.out_ready = (cyc >= 6);
         if4.in_valid  = (sent < 5);
         if (sent < 5) begin
            if4.din = xb[sent]; if4.in_tag = 8'(sent + 1); if4.in_mode = 1'b0;
         end
         #1;
         if (cyc == 5) begin
            chk("bp_in_ready_low", if4.in_ready, 0);
            chk("bp_accepts", sent, 3);
         end
         if (if4.out_valid) begin
            if (!if4.out_ready) begin
               if (held_ok && (if4.dout !== held || if4.out_tag !== held_tag)) held_bad++;
               held = if4.dout; held_tag = if4.out_tag; held_ok = 1'b1;
            end else begin
               if (q4_dat.size() == 0) chk("bp_extra", 1, 0);
               else begin
                  chk("bp_tag", if4.out_tag, q4_tag.pop_front());
                  chk("bp_dat", if4.dout, q4_dat.pop_front());
               end
               recv++;
            end
         end
         if (if4.in_valid && if4.in_ready) begin
            q4_dat.push_back(m4(1'b0, xb[sent]));
            q4_tag.push_back(8'(sent + 1));
            sent++;
            if (!if4.out_ready) acc_stall++;
         end
         tick();
      end
      if4.in_valid = 1'b0; if4.out_ready = 1'b1;
      chk("bp_stall_accepts", acc_stall, 3);
      chk("bp_held_stable", held_bad, 0);
      chk("bp_recv", recv, 5);
      tick();

      // Random round trip on four lanes
      for (int i = 0; i < 1000; i++) begin
         x4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         run4("rt_fp", 1'b0, x4, 8'(i), m4(1'b0, x4), r4);
         run4("rt_ip", 1'b1, r4, 8'(i + 1), x4, r4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
